// File: rtl/fpgapu_audio_pkg.sv
// Shared audio-path constants and the per-channel note timer state encoding.
// Imported by the note scheduler top level and its channel timers.
package fpgapu_audio_pkg;

  localparam int PITCH_W = 6;
  localparam int LEN_W   = 5;
  localparam int INST_W  = 4;
  localparam int REM_W   = 6;

  localparam logic [PITCH_W-1:0] PITCH_REST = 6'd0;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_WAIT = 2'd1,
    CH_PLAY = 2'd2
  } ch_state_e;

endpackage

// File: rtl/note_channel_timer.sv
// One voice channel: waits for a note, holds it for len+1 ticks, requests next.
// Ports: i_start/i_tick/i_run from top, note in, gate/trig/stb/pitch/inst out.
module note_channel_timer
  import fpgapu_audio_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_tick,
  input  logic               i_run,
  input  logic               i_valid,
  input  logic [PITCH_W-1:0] i_pitch,
  input  logic [LEN_W-1:0]   i_len,
  input  logic [INST_W-1:0]  i_inst,
  output logic               o_gate,
  output logic               o_trig,
  output logic               o_stb,
  output logic [PITCH_W-1:0] o_pitch,
  output logic [INST_W-1:0]  o_inst
);

  ch_state_e          state_q;
  logic [REM_W-1:0]   rem_q;
  logic               short_q;
  logic [PITCH_W-1:0] pitch_q;
  logic [INST_W-1:0]  inst_q;
  logic               trig_q;
  logic               stb_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= CH_IDLE;
      rem_q   <= '0;
      short_q <= 1'b0;
      pitch_q <= PITCH_REST;
      inst_q  <= '0;
      trig_q  <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      stb_q  <= 1'b0;
      unique case (state_q)
        CH_IDLE: begin
          if (i_start) begin
            state_q <= CH_WAIT;
            stb_q   <= 1'b1;
          end
        end
        CH_WAIT: begin
          // Ticks seen here are dropped; duration counts from the load.
          if (i_valid) begin
            state_q <= CH_PLAY;
            pitch_q <= i_pitch;
            inst_q  <= i_inst;
            rem_q   <= {1'b0, i_len} + 6'd1;
            short_q <= (i_len == '0);
            trig_q  <= (i_pitch != PITCH_REST);
          end
        end
        CH_PLAY: begin
          if (i_tick) begin
            rem_q <= rem_q - 6'd1;
            if (rem_q == 6'd1) begin
              state_q <= CH_WAIT;
              stb_q   <= 1'b1;
            end
          end
        end
        default: state_q <= CH_IDLE;
      endcase
    end
  end

  // Gate drops for the last tick of a note (articulation gap) unless the
  // note is only one tick long; pause forces it low without losing state.
  assign o_gate = i_run && (state_q == CH_PLAY) &&
                  (pitch_q != PITCH_REST) &&
                  ((rem_q > 6'd1) || short_q);
  assign o_trig  = trig_q;
  assign o_stb   = stb_q;
  assign o_pitch = pitch_q;
  assign o_inst  = inst_q;

endmodule

// File: rtl/note_scheduler.sv
// Tempo divider and start logic pacing NUM_CH note channel timers.
// Ports: run/tempo in, tick/strobes out, note inputs, voice outputs, started.
module note_scheduler
  import fpgapu_audio_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DIV_W  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_run,
  input  logic [DIV_W-1:0]          i_tempo_div,
  output logic                      o_tick,
  output logic [NUM_CH-1:0]         o_note_stb,
  input  logic [NUM_CH-1:0]         i_note_valid,
  input  logic [PITCH_W*NUM_CH-1:0] i_note_pitch,
  input  logic [LEN_W*NUM_CH-1:0]   i_note_len,
  input  logic [INST_W*NUM_CH-1:0]  i_note_instrument,
  output logic [NUM_CH-1:0]         o_voice_gate,
  output logic [NUM_CH-1:0]         o_voice_trig,
  output logic [PITCH_W*NUM_CH-1:0] o_voice_pitch,
  output logic [INST_W*NUM_CH-1:0]  o_voice_instrument,
  output logic                      o_started
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] term;
  logic             started_q;
  logic             start;

  // A divide of 0 behaves as 1: terminal value 0, tick every run cycle.
  assign term  = (i_tempo_div == '0) ? '0 : i_tempo_div - 1'b1;
  assign start = i_run && !started_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_run) begin
      // >= so a shrunken divide wraps immediately instead of running on.
      cnt_d = (cnt_q >= term) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      started_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (start) started_q <= 1'b1;
    end
  end

  assign o_tick    = i_rst_n && i_run && (cnt_q == term);
  assign o_started = started_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    note_channel_timer u_ch (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (start),
      .i_tick  (o_tick),
      .i_run   (i_run),
      .i_valid (i_note_valid[c]),
      .i_pitch (i_note_pitch[PITCH_W*c +: PITCH_W]),
      .i_len   (i_note_len[LEN_W*c +: LEN_W]),
      .i_inst  (i_note_instrument[INST_W*c +: INST_W]),
      .o_gate  (o_voice_gate[c]),
      .o_trig  (o_voice_trig[c]),
      .o_stb   (o_note_stb[c]),
      .o_pitch (o_voice_pitch[PITCH_W*c +: PITCH_W]),
      .o_inst  (o_voice_instrument[INST_W*c +: INST_W])
    );
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Directed vector bench for note_scheduler (NUM_CH=3, tempo divide 4).
// Table drives channel 0 cycle by cycle; pause and reset are hand sequences.
module tb_note_scheduler;

  localparam int NCH = 3;
  localparam int NV  = 57;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] div;
  logic        tick;
  logic [2:0]  stb;
  logic [2:0]  valid;
  logic [17:0] pitch;
  logic [14:0] len;
  logic [11:0] inst;
  logic [2:0]  gate;
  logic [2:0]  trig;
  logic [17:0] vpitch;
  logic [11:0] vinst;
  logic        started;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  note_scheduler #(.NUM_CH(NCH), .DIV_W(16)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_run             (run),
    .i_tempo_div       (div),
    .o_tick            (tick),
    .o_note_stb        (stb),
    .i_note_valid      (valid),
    .i_note_pitch      (pitch),
    .i_note_len        (len),
    .i_note_instrument (inst),
    .o_voice_gate      (gate),
    .o_voice_trig      (trig),
    .o_voice_pitch     (vpitch),
    .o_voice_instrument(vinst),
    .o_started         (started)
  );

  typedef struct {
    logic       valid;
    logic [5:0] pitch;
    logic [4:0] len;
    logic [3:0] inst;
    logic       e_tick;
    logic [2:0] e_stb;
    logic [2:0] e_gate;
    logic [2:0] e_trig;
    logic [5:0] e_pitch;
    logic [3:0] e_inst;
  } vec_t;

  vec_t tbl[NV];

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s @%0d: got %0h want %0h", nm, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(logic v, logic [5:0] p, logic [4:0] l,
                        logic [3:0] n);
    valid = {2'b00, v};
    pitch = {12'd0, p};
    len   = {10'd0, l};
    inst  = {8'd0, n};
  endtask

  task automatic setv(int k, logic [5:0] p, logic [4:0] l, logic [3:0] n);
    tbl[k].valid = 1'b1;
    tbl[k].pitch = p;
    tbl[k].len   = l;
    tbl[k].inst  = n;
  endtask

  int  ticks;
  bit  got;
  bit  bad_pause;

  initial begin
    for (int k = 0; k < NV; k++) begin
      tbl[k] = '{valid: 1'b0, pitch: 6'd0, len: 5'd0, inst: 4'd0,
                 e_tick: ((k % 4) == 3), e_stb: 3'b000, e_gate: 3'b000,
                 e_trig: 3'b000, e_pitch: 6'd0, e_inst: 4'd0};
      if (k >= 5 && k <= 19) begin
        tbl[k].e_pitch = 6'd10;
        tbl[k].e_inst  = 4'd7;
      end
      if (k >= 20 && k <= 27) begin
        tbl[k].e_pitch = 6'd5;
        tbl[k].e_inst  = 4'd1;
      end
      if (k >= 28 && k <= 47) tbl[k].e_inst = 4'd2;
      if (k >= 48) begin
        tbl[k].e_pitch = 6'd20;
        tbl[k].e_inst  = 4'd3;
      end
      if ((k >= 5 && k <= 11) || (k >= 20 && k <= 23) ||
          (k >= 48 && k <= 51))
        tbl[k].e_gate = 3'b001;
    end
    tbl[1].e_stb  = 3'b111;
    tbl[16].e_stb = 3'b001;
    tbl[24].e_stb = 3'b001;
    tbl[44].e_stb = 3'b001;
    tbl[56].e_stb = 3'b001;
    tbl[5].e_trig  = 3'b001;
    tbl[20].e_trig = 3'b001;
    tbl[48].e_trig = 3'b001;
    setv(4,  6'd10, 5'd2, 4'd7);
    setv(19, 6'd5,  5'd0, 4'd1);
    setv(27, 6'd0,  5'd3, 4'd2);
    setv(47, 6'd20, 5'd1, 4'd3);
    setv(49, 6'd33, 5'd7, 4'd9);

    rst_n = 1'b0;
    run   = 1'b0;
    div   = 16'd4;
    drive0(1'b0, 6'd0, 5'd0, 4'd0);
    repeat (3) step();
    chk("reset_outs", -1,
        {tick, stb, gate, trig, started, vpitch, vinst}, 32'd0);

    rst_n = 1'b1;
    for (int k = 0; k < NV; k++) begin
      run = 1'b1;
      drive0(tbl[k].valid, tbl[k].pitch, tbl[k].len, tbl[k].inst);
      #1;
      chk("tick",  k, tick, tbl[k].e_tick);
      chk("stb",   k, stb,  tbl[k].e_stb);
      chk("gate",  k, gate, tbl[k].e_gate);
      chk("trig",  k, trig, tbl[k].e_trig);
      chk("pitch", k, vpitch, {12'd0, tbl[k].e_pitch});
      chk("inst",  k, vinst,  {8'd0, tbl[k].e_inst});
      step();
    end

    // Mid-note pause: load 5-tick note, pause 10 cycles, count ticks to stb.
    drive0(1'b1, 6'd12, 5'd4, 4'd5);
    #1;
    chk("started", 0, started, 1'b1);
    step();
    drive0(1'b0, 6'd0, 5'd0, 4'd0);
    ticks = 0;
    got = 1'b0;
    bad_pause = 1'b0;
    for (int i = 1; i <= 200 && !got; i++) begin
      run = !(i >= 6 && i <= 15);
      #1;
      if (i == 1) chk("pz_trig", i, {trig, gate}, 6'b001_001);
      if (!run && (gate != 3'b000 || tick)) bad_pause = 1'b1;
      if (i == 16) chk("resume", i, {trig, gate}, 6'b000_001);
      if (stb[0]) got = 1'b1;
      else if (tick) ticks++;
      step();
    end
    run = 1'b1;
    chk("pz_stb_seen", 0, got, 1'b1);
    chk("pz_ticks", 0, ticks, 5);
    chk("pz_quiet", 0, bad_pause, 1'b0);

    // Reset in the middle of a note clears every output next cycle.
    drive0(1'b1, 6'd9, 5'd6, 4'd4);
    step();
    drive0(1'b0, 6'd0, 5'd0, 4'd0);
    step();
    #1;
    chk("pre_rst_gate", 0, {gate, vpitch[5:0]}, {3'b001, 6'd9});
    rst_n = 1'b0;
    step();
    #1;
    chk("rst_outs", 0,
        {tick, stb, gate, trig, started, vpitch, vinst}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
